// File: rtl/adder_sched_pkg.sv
// Shared definitions for the slice-serial adder scheduler.
// State encoding and default operand/slice widths.
package adder_sched_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SLICE = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_slice.sv
// SLICE-bit adder with carry in and carry out.
// Shared by both requesters of adder_scheduler.
module adder_slice
    import adder_sched_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    assign s    = full[SLICE-1:0];
    assign cout = full[SLICE];

endmodule

// File: rtl/adder_scheduler.sv
// Two-requester round-robin scheduler around one serial SLICE-bit adder.
// Define ADDER_SCHEDULER_CIN_EN to add per-requester carry-in ports.
module adder_scheduler
    import adder_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_req0_valid,
    output logic             io_req0_ready,
    input  logic [WIDTH-1:0] io_req0_lhs,
    input  logic [WIDTH-1:0] io_req0_rhs,
`ifdef ADDER_SCHEDULER_CIN_EN
    input  logic             io_req0_cin,
    input  logic             io_req1_cin,
`endif
    input  logic             io_req1_valid,
    output logic             io_req1_ready,
    input  logic [WIDTH-1:0] io_req1_lhs,
    input  logic [WIDTH-1:0] io_req1_rhs,
    output logic             io_resp_valid,
    input  logic             io_resp_ready,
    output logic [WIDTH-1:0] io_resp_sum,
    output logic             io_resp_cout,
    output logic             io_resp_id
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] lhs_q, lhs_d;
    logic [WIDTH-1:0] rhs_q, rhs_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
    logic             resp_cout_q, resp_cout_d;
    logic             resp_id_q, resp_id_d;

    logic             grant;
    logic             idle;
    logic             fire;
    logic             cin_sel;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_cout;

    // Contention goes to the side not granted last; a lone requester always wins.
    always_comb begin
        grant = ~last_q;
        if (io_req0_valid && io_req1_valid) begin
            grant = ~last_q;
        end else if (io_req0_valid) begin
            grant = 1'b0;
        end else if (io_req1_valid) begin
            grant = 1'b1;
        end
    end

    assign idle          = (state_q == IDLE);
    assign io_req0_ready = idle && !grant;
    assign io_req1_ready = idle && grant;
    assign fire          = idle && (grant ? io_req1_valid : io_req0_valid);

`ifdef ADDER_SCHEDULER_CIN_EN
    assign cin_sel = grant ? io_req1_cin : io_req0_cin;
`else
    assign cin_sel = 1'b0;
`endif

    always_comb begin
        sl_a = lhs_q[int'(k_q)*SLICE +: SLICE];
        sl_b = rhs_q[int'(k_q)*SLICE +: SLICE];
    end

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        carry_d      = carry_q;
        lhs_d        = lhs_q;
        rhs_d        = rhs_q;
        acc_d        = acc_q;
        id_d         = id_q;
        last_d       = last_q;
        resp_valid_d = resp_valid_q;
        resp_sum_d   = resp_sum_q;
        resp_cout_d  = resp_cout_q;
        resp_id_d    = resp_id_q;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    lhs_d   = grant ? io_req1_lhs : io_req0_lhs;
                    rhs_d   = grant ? io_req1_rhs : io_req0_rhs;
                    id_d    = grant;
                    last_d  = grant;
                    k_d     = '0;
                    carry_d = cin_sel;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[int'(k_q)*SLICE +: SLICE] = sl_s;
                carry_d = sl_cout;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    // Publish only on completion so outputs hold outside DONE.
                    k_d          = '0;
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_sum_d   = acc_d;
                    resp_cout_d  = sl_cout;
                    resp_id_d    = id_q;
                end
            end
            DONE: begin
                if (io_resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            carry_q      <= 1'b0;
            lhs_q        <= '0;
            rhs_q        <= '0;
            acc_q        <= '0;
            id_q         <= 1'b0;
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            carry_q      <= carry_d;
            lhs_q        <= lhs_d;
            rhs_q        <= rhs_d;
            acc_q        <= acc_d;
            id_q         <= id_d;
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_sum_q   <= resp_sum_d;
            resp_cout_q  <= resp_cout_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign io_resp_valid = resp_valid_q;
    assign io_resp_sum   = resp_sum_q;
    assign io_resp_cout  = resp_cout_q;
    assign io_resp_id    = resp_id_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// Self-checking bench for adder_scheduler (WIDTH=8, SLICE=2).
// Vector table plus reset, stall, abort and round-robin sequences.
module tb_adder_scheduler;

    localparam int WIDTH  = 8;
    localparam int SLICE  = 2;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_lhs, req0_rhs, req1_lhs, req1_rhs;
`ifdef ADDER_SCHEDULER_CIN_EN
    logic             cin0, cin1;
`endif
    logic             resp_valid, resp_ready;
    logic [WIDTH-1:0] resp_sum;
    logic             resp_cout, resp_id;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             id;
    } exp_t;

    typedef struct {
        logic             sel;
        logic [WIDTH-1:0] lhs;
        logic [WIDTH-1:0] rhs;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    exp_t             sb[$];
    vec_t             vecs[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] last_sum;
    logic             last_cout, last_id;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_scheduler #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_req0_valid (req0_valid),
        .io_req0_ready (req0_ready),
        .io_req0_lhs   (req0_lhs),
        .io_req0_rhs   (req0_rhs),
`ifdef ADDER_SCHEDULER_CIN_EN
        .io_req0_cin   (cin0),
        .io_req1_cin   (cin1),
`endif
        .io_req1_valid (req1_valid),
        .io_req1_ready (req1_ready),
        .io_req1_lhs   (req1_lhs),
        .io_req1_rhs   (req1_rhs),
        .io_resp_valid (resp_valid),
        .io_resp_ready (resp_ready),
        .io_resp_sum   (resp_sum),
        .io_resp_cout  (resp_cout),
        .io_resp_id    (resp_id)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("resp_sum", 32'(resp_sum), 32'(e.sum));
                chk("resp_cout", 32'(resp_cout), 32'(e.cout));
                chk("resp_id", 32'(resp_id), 32'(e.id));
                last_sum  = e.sum;
                last_cout = e.cout;
                last_id   = e.id;
            end
        end
    end

    task automatic clear_last();
        last_sum  = '0;
        last_cout = 1'b0;
        last_id   = 1'b0;
    endtask

    // Returns at the negedge where resp_valid is first seen.
    task automatic wait_resp(input int acc_cyc);
        bit seen = 0;
        bit busy = 0;
        bit first = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (first) begin
                chk("hold_sum", 32'(resp_sum), 32'(last_sum));
                chk("hold_cout_id", 32'({resp_cout, resp_id}),
                    32'({last_cout, last_id}));
                first = 0;
            end
            if (req0_ready || req1_ready) busy = 1;
            if (resp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("resp_seen", 32'(seen), 1);
        if (seen) chk("latency", cyc - acc_cyc, NSLICE);
        chk("busy_ready", 32'(busy), 0);
    endtask

    task automatic do_op(input vec_t v);
        bit acc = 0;
        int acc_cyc;
        exp_t e;
        if (!v.sel) begin
            req0_valid = 1'b1;
            req0_lhs   = v.lhs;
            req0_rhs   = v.rhs;
        end else begin
            req1_valid = 1'b1;
            req1_lhs   = v.lhs;
            req1_rhs   = v.rhs;
        end
`ifdef ADDER_SCHEDULER_CIN_EN
        cin0 = v.cin;
        cin1 = v.cin;
`endif
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (v.sel ? req1_ready : req0_ready) begin
                acc = 1;
                break;
            end
        end
        chk("accept", 32'(acc), 1);
        if (acc) begin
            e.sum  = v.sum;
            e.cout = v.cout;
            e.id   = v.sel;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (acc) begin
            wait_resp(acc_cyc);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        clear_last();
    endtask

    initial begin
        vec_t v;
        exp_t e;
        logic [WIDTH:0] full;
        int acc_cyc;
        int g;
        int gid[4];
        int gcyc[4];

        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_lhs   = '0;
        req0_rhs   = '0;
        req1_lhs   = '0;
        req1_rhs   = '0;
`ifdef ADDER_SCHEDULER_CIN_EN
        cin0 = 1'b0;
        cin1 = 1'b0;
`endif
        resp_ready = 1'b1;
        clear_last();

        vecs.push_back('{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{1'b1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0});
        vecs.push_back('{1'b0, 8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0});
        vecs.push_back('{1'b1, 8'hFE, 8'h03, 1'b0, 8'h01, 1'b1});
`ifdef ADDER_SCHEDULER_CIN_EN
        vecs.push_back('{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0});
        vecs.push_back('{1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1});
`endif

        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_sum", 32'(resp_sum), 0);
        chk("rst_cout_id", 32'({resp_cout, resp_id}), 0);
        chk("rst_one_ready", 32'(req0_ready && req1_ready), 0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) do_op(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            v.sel = i[0];
            v.lhs = 8'($urandom);
            v.rhs = 8'($urandom);
`ifdef ADDER_SCHEDULER_CIN_EN
            v.cin = 1'($urandom);
`else
            v.cin = 1'b0;
`endif
            full   = {1'b0, v.lhs} + {1'b0, v.rhs} + {8'd0, v.cin};
            v.sum  = full[WIDTH-1:0];
            v.cout = full[WIDTH];
            do_op(v);
        end

        // Consumer stalls for three DONE cycles.
        resp_ready = 1'b0;
        req1_valid = 1'b1;
        req1_lhs   = 8'h12;
        req1_rhs   = 8'h34;
`ifdef ADDER_SCHEDULER_CIN_EN
        cin1 = 1'b0;
`endif
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req1_ready) break;
        end
        chk("stall_accept", 32'(req1_ready), 1);
        e.sum  = 8'h46;
        e.cout = 1'b0;
        e.id   = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        req1_valid = 1'b0;
        wait_resp(acc_cyc);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            chk("stall_valid", 32'(resp_valid), 1);
            chk("stall_data", 32'({resp_cout, resp_id, resp_sum}),
                32'({1'b0, 1'b1, 8'h46}));
            chk("stall_ready", 32'({req0_ready, req1_ready}), 0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("stall_done_valid", 32'(resp_valid), 1);
        @(posedge clk);
        #1;
        chk("stall_popped", sb.size(), 0);
        @(negedge clk);
        chk("stall_idle_valid", 32'(resp_valid), 0);
        @(posedge clk);
        #1;

        // Reset during the second RUN cycle aborts silently.
        req0_valid = 1'b1;
        req0_lhs   = 8'h33;
        req0_rhs   = 8'h44;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        chk("abort_accept", 32'(req0_ready), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_run1_valid", 32'(resp_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_run2_valid", 32'(resp_valid), 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        req0_lhs = 8'h01;
        req0_rhs = 8'h02;
        clear_last();
        @(negedge clk);
        chk("abort_valid", 32'(resp_valid), 0);
        chk("abort_ready0", 32'(req0_ready), 1);
        chk("abort_sum", 32'(resp_sum), 0);
        e.sum  = 8'h03;
        e.cout = 1'b0;
        e.id   = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        req0_valid = 1'b0;
        wait_resp(acc_cyc);
        @(posedge clk);
        #1;

        // Both requesters held valid from reset.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_lhs   = 8'h10;
        req0_rhs   = 8'h01;
        req1_lhs   = 8'h20;
        req1_rhs   = 8'h02;
        do_reset();
        g = 0;
        for (int n = 0; n < 100 && g < 4; n++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) chk("rr_both_ready", 1, 0);
            if (req0_ready || req1_ready) begin
                gid[g] = req1_ready ? 1 : 0;
                e.id   = req1_ready;
                e.sum  = req1_ready ? 8'h22 : 8'h11;
                e.cout = 1'b0;
                sb.push_back(e);
                @(posedge clk);
                #1;
                gcyc[g] = cyc;
                g++;
                if (g == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        @(posedge clk);
        #1;
        chk("rr_drained", sb.size(), 0);
        chk("rr_count", g, 4);
        for (int i = 0; i < g; i++) begin
            chk($sformatf("rr_grant%0d", i), gid[i], i % 2);
        end
        for (int i = 1; i < g; i++) begin
            chk($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], NSLICE + 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_scheduler.md
ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, 8, operand/sum width in bits; must be a multiple of SLICE.
REQ-002 SHALL have parameter SLICE, 2, adder slice width in bits; NSLICE = WIDTH/SLICE.
REQ-003 SHALL use one clock and a synchronous, active-high reset; there are no other clocks or resets.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 io_req0_valid / io_req1_valid  input  1  requester n presents an add request.
REQ-007 io_req0_ready / io_req1_ready  output  1  request n accepted this cycle when valid&&ready.
REQ-008 io_req0_lhs, io_req0_rhs, io_req1_lhs, io_req1_rhs  input  WIDTH  operands.
REQ-009 io_resp_valid  output  1  result available.
REQ-010 io_resp_ready  input  1  consumer accepts result.
REQ-011 io_resp_sum  output  WIDTH  lhs+rhs(+cin) modulo 2^WIDTH.
REQ-012 io_resp_cout  output  1  carry out of bit WIDTH-1.
REQ-013 io_resp_id  output  1  index of the requester that owns the result.

Function
REQ-014 SHALL share one SLICE-bit adder between both requesters, computing a WIDTH-bit add over NSLICE cycles, LSB slice first, with the carry registered between slices.
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 IDLE: at most one io_reqN_ready high; if only one valid, it is granted; if both valid, grant the requester not granted last (round-robin); on handshake, latch lhs/rhs/id, clear slice counter, load carry (0, or cin per REQ-027), go RUN.
REQ-017 io_reqN_ready SHALL be 0 in RUN and DONE; ready may be high in IDLE without valid (granted side only).
REQ-018 RUN: each cycle add slice k of lhs, slice k of rhs and carry; write the result into sum bits [k*SLICE +: SLICE]; update carry; increment k; after k = NSLICE-1, go DONE with cout = final carry.
REQ-019 DONE: io_resp_valid = 1 with sum/cout/id stable until io_resp_valid && io_resp_ready, then go IDLE.
REQ-020 Latency: request handshake in cycle t makes io_resp_valid = 1 in cycle t+NSLICE+1; no new request is accepted in the cycle of the response handshake.
REQ-021 Throughput: at most one operation per NSLICE+2 cycles; sustained dual requests alternate 0,1,0,1.
REQ-022 Outputs io_resp_sum/cout/id SHALL be don't-care-free: hold their last values outside DONE.

Reset
REQ-023 reset SHALL force state IDLE, slice counter 0, carry 0, io_resp_valid 0, io_resp_sum 0, io_resp_cout 0, io_resp_id 0.
REQ-024 reset SHALL set last-grant to 1 so that requester 0 wins the first contention.
REQ-025 reset during RUN or DONE SHALL abort the operation silently; no response is produced for it.

Configuration
REQ-026 Macro ADDER_SCHEDULER_CIN_EN SHALL control the carry-in feature.
REQ-027 With the macro defined: add ports io_req0_cin and io_req1_cin (input, 1); the granted cin loads the initial carry. Without it: those ports are absent and the initial carry is 0.

Structure
REQ-028 Shared package adder_sched_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default WIDTH/SLICE constants.
REQ-029 The SLICE-bit adder with cin/cout SHALL be a sub-module named adder_slice, instantiated once.

Verification (WIDTH=8, SLICE=2)
REQ-030 req0 lhs=0x5A, rhs=0x3C, resp_ready=1 -> sum=0x96, cout=0, id=0, resp_valid exactly 5 cycles after accept.
REQ-031 req1 0xFF+0x01 -> sum=0x00, cout=1, id=1 (carry ripples through all 4 slices).
REQ-032 both valid from reset, held -> grants 0,1,0,1; each request accepted only in IDLE.
REQ-033 resp_ready low 3 cycles in DONE -> sum/cout/id stable, both req ready=0, completes on 4th cycle.
REQ-034 reset pulsed in RUN cycle 2 -> resp_valid stays 0; next cycle IDLE with req0 ready if valid.
REQ-035 ADDER_SCHEDULER_CIN_EN: 0x7F+0x00, cin=1 -> sum=0x80, cout=0; 0xFF+0x00, cin=1 -> sum=0x00, cout=1.
